// File: rtl/blink_ctrl_if.sv
// Write port and status bus of the multi-channel blink controller.
// The master drives single-cycle channel writes. The slave (the controller)
// returns the per-channel outputs, the busy flags and the prescaler tick.
interface blink_ctrl_if #(
  parameter int CHANNELS = 4,
  parameter int HW       = 8,
  parameter int CW       = 4
);

  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                wr_en;
  logic [CHW-1:0]      wr_ch;
  logic [1:0]          wr_mode;
  logic [HW-1:0]       wr_half;
  logic [CW-1:0]       wr_cnt;
  logic [CHANNELS-1:0] out;
  logic [CHANNELS-1:0] busy;
  logic                tick;

  modport master (
    output wr_en, wr_ch, wr_mode, wr_half, wr_cnt,
    input  out, busy, tick
  );

  modport slave (
    input  wr_en, wr_ch, wr_mode, wr_half, wr_cnt,
    output out, busy, tick
  );

endinterface

// File: rtl/blink_ctrl.sv
// Multi-channel LED/segment blink controller.
// A shared prescaler produces one tick every 2^PRESC_X clocks. Each channel
// runs its own OFF/ON/BLINK/BURST state machine and advances on that tick.
// Channels are programmed through a single-cycle write port. A write to a
// channel always takes priority over a tick arriving on the same edge.
module blink_ctrl #(
  parameter int CHANNELS = 4,
  parameter int PRESC_X  = 12,
  parameter int HW       = 8,
  parameter int CW       = 4
) (
  input logic         clk,
  input logic         rst,
  blink_ctrl_if.slave bus
);

  // Channel modes double as FSM states: the 2-bit write code maps directly.
  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  // Shared prescaler
  logic [PRESC_X-1:0] presc_q;
  logic [PRESC_X-1:0] presc_d;
  logic               tick_q;
  logic               tick_d;

  // Per-channel state
  mode_e               state_q [CHANNELS];
  logic [HW-1:0]       half_q  [CHANNELS];
  logic [HW-1:0]       phase_q [CHANNELS];
  logic [CW-1:0]       rem_q   [CHANNELS];
  logic [CHANNELS-1:0] out_q;

  // Decoded write request
  logic [CHANNELS-1:0] wrSel;
  logic [HW-1:0]       wrHalfEff;
  mode_e               wrMode;

  // Free-running prescaler. The tick is registered on the wrap-around edge,
  // so the first tick appears 2^PRESC_X cycles after reset release.
  always_comb begin
    presc_d = presc_q + PRESC_X'(1);
    tick_d  = &presc_q;
  end

  // Prescaler and tick registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  // Write decode. An index that matches no channel selects nothing, so
  // out-of-range writes fall away here. A half-period of zero is promoted
  // to one so that the terminal-phase compare is never half-1 = all-ones.
  always_comb begin
    wrSel     = '0;
    wrHalfEff = (bus.wr_half == '0) ? HW'(1) : bus.wr_half;
    wrMode    = mode_e'(bus.wr_mode);
    for (int i = 0; i < CHANNELS; i++) begin
      wrSel[i] = bus.wr_en && (int'(bus.wr_ch) == i);
    end
  end

  // Per-channel FSMs. A write restarts the channel from phase 0 and discards
  // any coincident tick for that channel only. In BLINK/BURST each tick
  // advances the phase; the terminal phase toggles the output. In BURST a
  // falling toggle consumes one pulse, and the last one drops back to OFF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= MODE_OFF;
        half_q[i]  <= HW'(1);
        phase_q[i] <= '0;
        rem_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wrSel[i]) begin
          half_q[i]  <= wrHalfEff;
          phase_q[i] <= '0;
          case (wrMode)
            MODE_OFF: begin
              state_q[i] <= MODE_OFF;
              out_q[i]   <= 1'b0;
            end
            MODE_ON: begin
              state_q[i] <= MODE_ON;
              out_q[i]   <= 1'b1;
            end
            MODE_BLINK: begin
              state_q[i] <= MODE_BLINK;
              out_q[i]   <= 1'b1;
            end
            MODE_BURST: begin
              if (bus.wr_cnt != '0) begin
                state_q[i] <= MODE_BURST;
                out_q[i]   <= 1'b1;
                rem_q[i]   <= bus.wr_cnt;
              end else begin
                state_q[i] <= MODE_OFF;
                out_q[i]   <= 1'b0;
              end
            end
            default: begin
              state_q[i] <= MODE_OFF;
              out_q[i]   <= 1'b0;
            end
          endcase
        end else if (tick_q && (state_q[i] == MODE_BLINK || state_q[i] == MODE_BURST)) begin
          if (phase_q[i] == half_q[i] - HW'(1)) begin
            phase_q[i] <= '0;
            out_q[i]   <= ~out_q[i];
            if (state_q[i] == MODE_BURST && out_q[i]) begin
              rem_q[i] <= rem_q[i] - CW'(1);
              if (rem_q[i] == CW'(1)) begin
                state_q[i] <= MODE_OFF;
              end
            end
          end else begin
            phase_q[i] <= phase_q[i] + HW'(1);
          end
        end
      end
    end
  end

  // Busy flags follow the registered state, so they change on the same edge
  // as the output.
  always_comb begin
    bus.busy = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bus.busy[i] = (state_q[i] == MODE_BURST);
    end
  end

  assign bus.out  = out_q;
  assign bus.tick = tick_q;

endmodule

// File: tb/tb_blink_ctrl.sv
// Testbench for blink_ctrl with 3 channels and a 4-cycle prescaler.
// A per-edge vector table covers BLINK, ON, out-of-range writes and a write
// that lands on a tick. Hand-written sequences cover burst, override,
// zero-count burst and asynchronous reset.
module tb_blink_ctrl;

  localparam int CHANNELS = 3;
  localparam int PRESC_X  = 2;
  localparam int HW       = 8;
  localparam int CW       = 4;

  typedef struct {
    logic       en;
    logic [1:0] ch;
    logic [1:0] mode;
    logic [7:0] half;
    logic [3:0] cnt;
    logic [2:0] expOut;
    logic [2:0] expBusy;
    logic       expTick;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   nCompared   = 0;
  int   nMismatched = 0;
  vec_t vecs [29];

  always #5 clk = ~clk;

  blink_ctrl_if #(.CHANNELS(CHANNELS), .HW(HW), .CW(CW)) bif ();

  blink_ctrl #(
    .CHANNELS(CHANNELS),
    .PRESC_X (PRESC_X),
    .HW      (HW),
    .CW      (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  function automatic vec_t mk(input logic en, input logic [1:0] ch, input logic [1:0] mode,
                              input logic [7:0] half, input logic [3:0] cnt,
                              input logic [2:0] expOut, input logic [2:0] expBusy,
                              input logic expTick);
    vec_t v;
    v.en = en; v.ch = ch; v.mode = mode; v.half = half; v.cnt = cnt;
    v.expOut = expOut; v.expBusy = expBusy; v.expTick = expTick;
    return v;
  endfunction

  // Drive one write (or idle) cycle and settle just after the edge.
  task automatic applyStimulus(input logic en, input logic [1:0] ch, input logic [1:0] mode,
                               input logic [7:0] half, input logic [3:0] cnt);
    bif.wr_en   = en;
    bif.wr_ch   = ch;
    bif.wr_mode = mode;
    bif.wr_half = half;
    bif.wr_cnt  = cnt;
    @(posedge clk);
    #1;
    bif.wr_en = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] expOut, input logic [2:0] expBusy);
    nCompared++;
    if (bif.out !== expOut) begin
      nMismatched++;
      $display("[TB] FAIL %s out: got %b want %b", name, bif.out, expOut);
    end
    nCompared++;
    if (bif.busy !== expBusy) begin
      nMismatched++;
      $display("[TB] FAIL %s busy: got %b want %b", name, bif.busy, expBusy);
    end
  endtask

  task automatic checkTick(input string name, input logic expTick);
    nCompared++;
    if (bif.tick !== expTick) begin
      nMismatched++;
      $display("[TB] FAIL %s tick: got %b want %b", name, bif.tick, expTick);
    end
  endtask

  // Hold reset for 3 edges and release between edges; the next edge is
  // edge 1 of the following sequence.
  task automatic doReset();
    rst         = 1'b1;
    bif.wr_en   = 1'b0;
    bif.wr_ch   = '0;
    bif.wr_mode = '0;
    bif.wr_half = '0;
    bif.wr_cnt  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset", 3'b000, 3'b000);
    checkTick("reset", 1'b0);
  endtask

  initial begin
    // Edge-by-edge table. Ticks consumed by channels on edges 5, 9, 13, ...
    // ch0 BLINK half=3 toggles at 13, 25; ch2 half=0 acts as half=1;
    // ch2 rewrite on tick edge 17 restarts phase, so next toggle is at 25.
    vecs[0]  = mk(1'b1, 2'd0, 2'd2, 8'd3, 4'd0, 3'b001, 3'b000, 1'b0);
    vecs[1]  = mk(1'b1, 2'd2, 2'd2, 8'd0, 4'd0, 3'b101, 3'b000, 1'b0);
    vecs[2]  = mk(1'b1, 2'd1, 2'd1, 8'd0, 4'd0, 3'b111, 3'b000, 1'b0);
    vecs[3]  = mk(1'b0, 2'd0, 2'd0, 8'd0, 4'd0, 3'b111, 3'b000, 1'b1);
    vecs[4]  = mk(1'b0, 2'd0, 2'd0, 8'd0, 4'd0, 3'b011, 3'b000, 1'b0);
    vecs[5]  = mk(1'b0, 2'd0, 2'd0, 8'd0, 4'd0, 3'b011, 3'b000, 1'b0);
    vecs[6]  = mk(1'b1, 2'd3, 2'd0, 8'd0, 4'd0, 3'b011, 3'b000, 1'b0);
    vecs[7]  = mk(1'b0, 2'd0, 2'd0, 8'd0, 4'd0, 3'b011, 3'b000, 1'b1);
    vecs[8]  = mk(1'b0, 2'd0, 2'd0, 8'd0, 4'd0, 3'b111, 3'b000, 1'b0);
    vecs[9]  = mk(1'b0, 2'd0, 2'd0, 8'd0, 4'd0, 3'b111, 3'b000, 1'b0);
    vecs[10] = mk(1'b0, 2'd0, 2'd0, 8'd0, 4'd0, 3'b111, 3'b000, 1'b0);
    vecs[11] = mk(1'b0, 2'd0, 2'd0, 8'd0, 4'd0, 3'b111, 3'b000, 1'b1);
    vecs[12] = mk(1'b0, 2'd0, 2'd0, 8'd0, 4'd0, 3'b010, 3'b000, 1'b0);
    vecs[13] = mk(1'b0, 2'd0, 2'd0, 8'd0, 4'd0, 3'b010, 3'b000, 1'b0);
    vecs[14] = mk(1'b0, 2'd0, 2'd0, 8'd0, 4'd0, 3'b010, 3'b000, 1'b0);
    vecs[15] = mk(1'b0, 2'd0, 2'd0, 8'd0, 4'd0, 3'b010, 3'b000, 1'b1);
    vecs[16] = mk(1'b1, 2'd2, 2'd2, 8'd2, 4'd0, 3'b110, 3'b000, 1'b0);
    vecs[17] = mk(1'b0, 2'd0, 2'd0, 8'd0, 4'd0, 3'b110, 3'b000, 1'b0);
    vecs[18] = mk(1'b0, 2'd0, 2'd0, 8'd0, 4'd0, 3'b110, 3'b000, 1'b0);
    vecs[19] = mk(1'b0, 2'd0, 2'd0, 8'd0, 4'd0, 3'b110, 3'b000, 1'b1);
    vecs[20] = mk(1'b0, 2'd0, 2'd0, 8'd0, 4'd0, 3'b110, 3'b000, 1'b0);
    vecs[21] = mk(1'b0, 2'd0, 2'd0, 8'd0, 4'd0, 3'b110, 3'b000, 1'b0);
    vecs[22] = mk(1'b0, 2'd0, 2'd0, 8'd0, 4'd0, 3'b110, 3'b000, 1'b0);
    vecs[23] = mk(1'b0, 2'd0, 2'd0, 8'd0, 4'd0, 3'b110, 3'b000, 1'b1);
    vecs[24] = mk(1'b0, 2'd0, 2'd0, 8'd0, 4'd0, 3'b011, 3'b000, 1'b0);
    vecs[25] = mk(1'b0, 2'd0, 2'd0, 8'd0, 4'd0, 3'b011, 3'b000, 1'b0);
    vecs[26] = mk(1'b1, 2'd1, 2'd0, 8'd0, 4'd0, 3'b001, 3'b000, 1'b0);
    vecs[27] = mk(1'b1, 2'd0, 2'd0, 8'd0, 4'd0, 3'b000, 3'b000, 1'b1);
    vecs[28] = mk(1'b1, 2'd2, 2'd0, 8'd0, 4'd0, 3'b000, 3'b000, 1'b0);

    doReset();
    for (int k = 0; k < 29; k++) begin
      applyStimulus(vecs[k].en, vecs[k].ch, vecs[k].mode, vecs[k].half, vecs[k].cnt);
      checkOutput($sformatf("vec%0d", k), vecs[k].expOut, vecs[k].expBusy);
      checkTick($sformatf("vec%0d", k), vecs[k].expTick);
    end

    // BURST ch1 half=1 cnt=2: high 1-4, low 5-8, high 9-12, OFF from 13.
    doReset();
    for (int e = 1; e <= 20; e++) begin
      logic o1;
      logic b1;
      if (e == 1) applyStimulus(1'b1, 2'd1, 2'd3, 8'd1, 4'd2);
      else        applyStimulus(1'b0, 2'd0, 2'd0, 8'd0, 4'd0);
      o1 = (e < 5) || (e >= 9 && e < 13);
      b1 = (e < 13);
      checkOutput($sformatf("burst e%0d", e), {1'b0, o1, 1'b0}, {1'b0, b1, 1'b0});
    end

    // Long burst on ch1, ch2 forced ON mid-burst without disturbing ch1.
    doReset();
    for (int e = 1; e <= 20; e++) begin
      logic o1;
      logic o2;
      if (e == 1)      applyStimulus(1'b1, 2'd1, 2'd3, 8'd1, 4'd5);
      else if (e == 7) applyStimulus(1'b1, 2'd2, 2'd1, 8'd0, 4'd0);
      else             applyStimulus(1'b0, 2'd0, 2'd0, 8'd0, 4'd0);
      o1 = (((e - 1) / 4) % 2) == 0;
      o2 = (e >= 7);
      checkOutput($sformatf("override e%0d", e), {o2, o1, 1'b0}, 3'b010);
    end
    applyStimulus(1'b0, 2'd0, 2'd0, 8'd0, 4'd0);
    applyStimulus(1'b1, 2'd1, 2'd0, 8'd0, 4'd0);
    checkOutput("ch1 off", 3'b100, 3'b000);
    applyStimulus(1'b0, 2'd0, 2'd0, 8'd0, 4'd0);
    checkOutput("ch1 off hold", 3'b100, 3'b000);
    applyStimulus(1'b1, 2'd0, 2'd1, 8'd0, 4'd0);
    checkOutput("ch0 on", 3'b101, 3'b000);
    applyStimulus(1'b1, 2'd0, 2'd3, 8'd3, 4'd0);
    checkOutput("burst cnt0", 3'b100, 3'b000);
    repeat (8) applyStimulus(1'b0, 2'd0, 2'd0, 8'd0, 4'd0);
    checkOutput("idle after cnt0", 3'b100, 3'b000);

    // Async reset between edges with ch0 BLINK and ch1 BURST running.
    doReset();
    applyStimulus(1'b1, 2'd0, 2'd2, 8'd1, 4'd0);
    applyStimulus(1'b1, 2'd1, 2'd3, 8'd2, 4'd3);
    repeat (6) applyStimulus(1'b0, 2'd0, 2'd0, 8'd0, 4'd0);
    checkOutput("pre-reset", 3'b010, 3'b010);
    checkTick("pre-reset", 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset", 3'b000, 3'b000);
    checkTick("async reset", 1'b0);
    #2;
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      applyStimulus(1'b0, 2'd0, 2'd0, 8'd0, 4'd0);
      checkOutput($sformatf("post-reset e%0d", e), 3'b000, 3'b000);
      checkTick($sformatf("post-reset e%0d", e), (e % 4) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
